// File: rtl/bus_interconnect.sv
// rtl/bus_interconnect.sv - picorv32 native bus to multi-slave interconnect with timeout and error capture
`timescale 1ns/1ps

module bus_interconnect #(
    parameter int          NUM_SLAVES  = 8,
    parameter int          SEL_LO      = 12,
    parameter int          SEL_W       = 4,
    parameter logic [63:0] WAIT_STATES = 64'd0,
    parameter logic [15:0] READY_MASK  = 16'd0,
    parameter int          TIMEOUT     = 1024,
    parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       m_valid,
    output logic                       m_ready,
    input  logic [31:0]                m_addr,
    input  logic [31:0]                m_wdata,
    input  logic [3:0]                 m_wstrb,
    output logic [31:0]                m_rdata,
    output logic [NUM_SLAVES-1:0]      s_sel,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wdata,
    output logic [3:0]                 s_wstrb,
    input  logic [32*NUM_SLAVES-1:0]   s_rdata,
    input  logic [NUM_SLAVES-1:0]      s_ready,
    output logic                       err_irq,
    output logic [31:0]                err_addr,
    output logic [7:0]                 err_count
);

    // Counter is shared between fixed wait states (4 bits) and the timeout count
    localparam int CNT_W = ($clog2(TIMEOUT) > 4) ? $clog2(TIMEOUT) : 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [31:0]             r_err_addr;
    logic [7:0]              r_err_count;

    logic [SEL_W-1:0]        w_idx;
    logic [NUM_SLAVES-1:0]   w_hit;
    logic                    w_mapped;
    logic [3:0]              w_wait;
    logic                    w_rmode;
    logic                    w_sready;
    logic [31:0]             w_slave_rdata;
    logic                    w_sel_en;

    assign w_idx    = m_addr[SEL_LO+SEL_W-1:SEL_LO];
    assign w_mapped = |w_hit;

    // Decode the region field into a one-hot hit and pick that slave's attributes
    always_comb begin
        w_hit         = '0;
        w_wait        = 4'd0;
        w_rmode       = 1'b0;
        w_sready      = 1'b0;
        w_slave_rdata = 32'd0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (32'(w_idx) == i) begin
                w_hit[i]      = 1'b1;
                w_wait        = WAIT_STATES[4*i +: 4];
                w_rmode       = READY_MASK[i];
                w_sready      = s_ready[i];
                w_slave_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    // Transfer FSM: wait-state / timeout counting and error capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_err_addr  <= 32'd0;
            r_err_count <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (m_valid) begin
                        if (!w_mapped) begin
                            r_state <= ST_ERR;
                        end else if (w_rmode) begin
                            // A slave that is already ready finishes in this cycle
                            if (!w_sready) begin
                                r_cnt   <= CNT_W'(1);
                                r_state <= ST_WAIT;
                            end
                        end else begin
                            r_cnt   <= CNT_W'(w_wait);
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!m_valid) begin
                        // Master abandoned the request: drop it silently
                        r_state <= ST_IDLE;
                    end else if (w_rmode) begin
                        if (w_sready) begin
                            r_state <= ST_IDLE;
                        end else if (r_cnt == CNT_W'(TIMEOUT-1)) begin
                            r_state <= ST_ERR;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        if (r_cnt == '0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                ST_ERR: begin
                    r_err_addr <= m_addr;
                    if (r_err_count != 8'hFF) begin
                        r_err_count <= r_err_count + 8'd1;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Completion strobe: same-cycle for ready slaves, counted for fixed slaves, forced on error
    always_comb begin
        m_ready = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: m_ready = m_valid && w_mapped && w_rmode && w_sready;
                ST_WAIT: m_ready = m_valid && (w_rmode ? w_sready : (r_cnt == '0));
                ST_ERR:  m_ready = 1'b1;
                default: m_ready = 1'b0;
            endcase
        end
    end

    assign w_sel_en  = m_valid && !rst && (r_state != ST_ERR);
    assign s_sel     = w_sel_en ? w_hit : '0;
    assign s_wstrb   = (|s_sel) ? m_wstrb : 4'd0;
    assign s_addr    = m_addr;
    assign s_wdata   = m_wdata;
    assign m_rdata   = (r_state == ST_ERR) ? ERR_DATA : w_slave_rdata;
    assign err_irq   = (r_state == ST_ERR);
    assign err_addr  = r_err_addr;
    assign err_count = r_err_count;

endmodule
